// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared state encoding and constants for the 6:3 counter BIST
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RST_CHK = 2'd1,
    ST_RUN     = 2'd2,
    ST_DONE    = 2'd3
  } bist_state_e;

  localparam logic [15:0] MISR_POLY     = 16'h1021;
  localparam int          LFSR_TAP_A    = 5;
  localparam int          LFSR_TAP_B    = 4;
  localparam int          PATTERN_COUNT = 64;

  function automatic logic [2:0] popcount6(input logic [5:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < 6; i++) c = c + {2'b00, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/bist_counter_ctrl_if.sv
// rtl/bist_counter_ctrl_if.sv - host and CUT signal bundle for the BIST controller
interface bist_counter_ctrl_if #(
  parameter int MISR_W = 16
);
  logic              start;
  logic              abort;
  logic              mode;
  logic [5:0]        cut_x;
  logic              cut_reset;
  logic [2:0]        cut_o;
  logic              busy;
  logic              done;
  logic              pass;
  logic [6:0]        fail_count;
  logic [6:0]        first_fail_pat;
  logic              first_fail_vld;
  logic [MISR_W-1:0] signature;

  modport master (
    output start, abort, mode, cut_o,
    input  cut_x, cut_reset, busy, done, pass, fail_count,
           first_fail_pat, first_fail_vld, signature
  );

  modport slave (
    input  start, abort, mode, cut_o,
    output cut_x, cut_reset, busy, done, pass, fail_count,
           first_fail_pat, first_fail_vld, signature
  );
endinterface

// File: rtl/bist_pattern_gen.sv
// rtl/bist_pattern_gen.sv - 64-entry pattern source: binary count or LFSR plus all-zero
module bist_pattern_gen
  import bist_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic       advance,
  input  logic       mode,
  input  logic [5:0] seed,
  output logic [5:0] pattern,
  output logic       last
);

  logic [5:0] pat_q, pat_d;
  logic [5:0] cnt_q, cnt_d;
  logic       mode_q, mode_d;

  always_comb begin
    pat_d  = pat_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    if (load) begin
      pat_d  = mode ? seed : 6'h00;
      cnt_d  = '0;
      mode_d = mode;
    end else if (advance) begin
      cnt_d = cnt_q + 6'd1;
      if (!mode_q)
        pat_d = pat_q + 6'd1;
      // The LFSR never reaches zero, so the all-zero pattern is appended after its 63 states.
      else if (cnt_q == 6'(PATTERN_COUNT - 2))
        pat_d = 6'h00;
      else
        pat_d = {pat_q[4:0], pat_q[LFSR_TAP_A] ^ pat_q[LFSR_TAP_B]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_q  <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end

  assign pattern = pat_q;
  assign last    = (cnt_q == 6'(PATTERN_COUNT - 1));

endmodule

// File: rtl/bist_counter_ctrl.sv
// rtl/bist_counter_ctrl.sv - BIST sequencer for the 6:3 counter: reset check, sweep, compare, MISR
module bist_counter_ctrl
  import bist_pkg::*;
#(
  parameter int                MISR_W    = 16,
  parameter logic [MISR_W-1:0] MISR_SEED = 16'hFFFF,
  parameter logic [5:0]        LFSR_SEED = 6'b000001
) (
  input  logic               clk,
  input  logic               reset_n,
  bist_counter_ctrl_if.slave bus
);

  bist_state_e       state_q, state_d;
  logic [5:0]        cut_x_q, cut_x_d;
  logic              cut_reset_q, cut_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [6:0]        fail_q, fail_d;
  logic [6:0]        ffp_q, ffp_d;
  logic              ffv_q, ffv_d;
  logic [MISR_W-1:0] sig_q, sig_d;
  logic              last_q, last_d;

  logic              gen_load, gen_advance, gen_last;
  logic [5:0]        gen_pattern;
  logic [2:0]        expected;
  logic [MISR_W-1:0] misr_next;

  bist_pattern_gen u_pattern_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (gen_load),
    .advance (gen_advance),
    .mode    (bus.mode),
    .seed    (LFSR_SEED),
    .pattern (gen_pattern),
    .last    (gen_last)
  );

  assign misr_next = {sig_q[MISR_W-2:0], sig_q[MISR_W-1]}
                   ^ (sig_q[MISR_W-1] ? MISR_W'(MISR_POLY) : '0)
                   ^ MISR_W'(bus.cut_o);

  always_comb begin
    state_d     = state_q;
    cut_x_d     = cut_x_q;
    cut_reset_d = cut_reset_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    ffp_d       = ffp_q;
    ffv_d       = ffv_q;
    sig_d       = sig_q;
    last_d      = last_q;
    gen_load    = 1'b0;
    gen_advance = 1'b0;
    expected    = (state_q == ST_RST_CHK) ? 3'b000 : popcount6(cut_x_q);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d     = ST_RST_CHK;
          cut_x_d     = 6'h3F;
          cut_reset_d = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          fail_d      = '0;
          ffv_d       = 1'b0;
          sig_d       = MISR_SEED;
          last_d      = 1'b0;
          gen_load    = 1'b1;
        end
      end
      ST_RST_CHK, ST_RUN: begin
        if (bus.abort) begin
          state_d     = ST_IDLE;
          cut_x_d     = 6'h00;
          cut_reset_d = 1'b1;
          busy_d      = 1'b0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
        end else begin
          if (bus.cut_o != expected) begin
            fail_d = fail_q + 7'd1;
            if (!ffv_q) begin
              ffp_d = {(state_q == ST_RST_CHK), cut_x_q};
              ffv_d = 1'b1;
            end
          end
          if (state_q == ST_RUN) sig_d = misr_next;
          // cut_x is loaded one pattern ahead; last_q marks that the final pattern is on the CUT.
          if (state_q == ST_RUN && last_q) begin
            state_d     = ST_DONE;
            cut_x_d     = 6'h00;
            cut_reset_d = 1'b1;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            pass_d      = (fail_d == 7'd0);
          end else begin
            state_d     = ST_RUN;
            cut_reset_d = 1'b0;
            cut_x_d     = gen_pattern;
            last_d      = gen_last;
            gen_advance = !gen_last;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cut_x_q     <= '0;
      cut_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= '0;
      ffp_q       <= '0;
      ffv_q       <= 1'b0;
      sig_q       <= MISR_SEED;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cut_x_q     <= cut_x_d;
      cut_reset_q <= cut_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      ffp_q       <= ffp_d;
      ffv_q       <= ffv_d;
      sig_q       <= sig_d;
      last_q      <= last_d;
    end
  end

  assign bus.cut_x          = cut_x_q;
  assign bus.cut_reset      = cut_reset_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.fail_count     = fail_q;
  assign bus.first_fail_pat = ffp_q;
  assign bus.first_fail_vld = ffv_q;
  assign bus.signature      = sig_q;

endmodule

// File: tb/tb_bist_counter_ctrl.sv
// tb/tb_bist_counter_ctrl.sv - scoreboard bench for bist_counter_ctrl with CUT fault models
module tb_bist_counter_ctrl;

  typedef struct {
    logic [6:0]  fails;
    logic [6:0]  ffp;
    logic        ffv;
    logic        pass;
    logic [15:0] sig;
    logic        mode;
    int          fault;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   fault = 0;
  int   total = 0;
  int   bad = 0;

  exp_t       exp_q[$];
  logic [5:0] exp_pat_q[$];

  always #5 clk = ~clk;

  bist_counter_ctrl_if #(.MISR_W(16)) bif ();

  bist_counter_ctrl #(
    .MISR_W    (16),
    .MISR_SEED (16'hFFFF),
    .LFSR_SEED (6'b000001)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif.slave)
  );

  // fault 0: good counter; 1: o[1] stuck-at-0; 2: ignores its reset
  function automatic logic [2:0] cut_ref(input logic [5:0] x, input logic rst, input int f);
    logic [2:0] r;
    r = 3'($countones(x));
    if (rst && f != 2) r = 3'b000;
    if (f == 1) r[1] = 1'b0;
    return r;
  endfunction

  always_comb bif.cut_o = cut_ref(bif.cut_x, bif.cut_reset, fault);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_expected(input logic m, input int f);
    exp_t e;
    int   pats[$];
    int   cur, s, r, nf;
    cur = 1;
    for (int i = 0; i < 64; i++) begin
      if (!m) pats.push_back(i);
      else if (i == 63) pats.push_back(0);
      else begin
        pats.push_back(cur);
        cur = ((cur << 1) & 63) | (((cur >> 5) ^ (cur >> 4)) & 1);
      end
    end
    nf = 0; e.ffv = 1'b0; e.ffp = '0; s = 16'hFFFF;
    if (cut_ref(6'h3F, 1'b1, f) != 3'b000) begin
      nf++; e.ffv = 1'b1; e.ffp = 7'h7F;
    end
    foreach (pats[i]) begin
      r = int'(cut_ref(6'(pats[i]), 1'b0, f));
      if (r != $countones(pats[i])) begin
        nf++;
        if (!e.ffv) begin e.ffv = 1'b1; e.ffp = 7'(pats[i]); end
      end
      s = ((((s << 1) | (s >> 15)) & 16'hFFFF) ^ (((s >> 15) & 1) != 0 ? 16'h1021 : 0)) ^ r;
      exp_pat_q.push_back(6'(pats[i]));
    end
    e.fails = 7'(nf); e.pass = (nf == 0); e.sig = 16'(s); e.mode = m; e.fault = f;
    exp_q.push_back(e);
  endtask

  // Monitor: tracks each busy window and scores the result when done rises.
  initial begin
    logic        busy_prev, done_prev, have_m0;
    logic [63:0] seen;
    logic [15:0] sig_m0;
    int          busy_len, pat_err;
    exp_t        e;
    busy_prev = 0; done_prev = 0; have_m0 = 0; seen = '0; sig_m0 = '0;
    busy_len = 0; pat_err = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        busy_prev = 0; done_prev = 0;
      end else begin
        if (bif.busy && !busy_prev) begin busy_len = 0; seen = '0; pat_err = 0; end
        if (bif.busy) busy_len++;
        if (bif.busy && !bif.cut_reset) begin
          seen[bif.cut_x] = 1'b1;
          if (exp_pat_q.size() == 0) pat_err++;
          else if (exp_pat_q.pop_front() != bif.cut_x) pat_err++;
        end
        if (bif.done && !done_prev) begin
          if (exp_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
          else begin
            e = exp_q.pop_front();
            check("busy_len", 64'(busy_len), 64'd65);
            check("done_follows_busy", 64'(busy_prev), 64'd1);
            check("pattern_order_errs", 64'(pat_err), 64'd0);
            check("all_64_applied", seen, {64{1'b1}});
            check("fail_count", 64'(bif.fail_count), 64'(e.fails));
            check("first_fail_vld", 64'(bif.first_fail_vld), 64'(e.ffv));
            if (e.ffv) check("first_fail_pat", 64'(bif.first_fail_pat), 64'(e.ffp));
            check("pass", 64'(bif.pass), 64'(e.pass));
            check("signature", 64'(bif.signature), 64'(e.sig));
            if (e.fault == 0 && !e.mode) begin have_m0 = 1; sig_m0 = bif.signature; end
            if (e.fault == 0 && e.mode && have_m0)
              check("mode1_sig_differs", 64'(bif.signature == sig_m0), 64'd0);
          end
        end
        busy_prev = bif.busy; done_prev = bif.done;
      end
    end
  end

  function automatic logic [40:0] out_vec();
    return {bif.cut_reset, bif.cut_x, bif.busy, bif.done, bif.pass, bif.fail_count,
            bif.first_fail_pat, bif.first_fail_vld, bif.signature};
  endfunction

  localparam logic [40:0] RESET_VEC = {1'b1, 6'h00, 3'b000, 7'h00, 7'h00, 1'b0, 16'hFFFF};

  task automatic wait_done(input string name);
    bit seen_done;
    seen_done = 0;
    for (int i = 0; i < 200 && !seen_done; i++) begin
      @(negedge clk);
      if (bif.done) seen_done = 1;
    end
    if (!seen_done) check(name, 64'd0, 64'd1);
  endtask

  task automatic run_full(input logic m, input int f, input logic with_abort);
    fault = f;
    push_expected(m, f);
    @(negedge clk);
    bif.mode = m; bif.start = 1'b1; bif.abort = with_abort;
    @(negedge clk);
    bif.start = 1'b0; bif.abort = 1'b0; bif.mode = 1'($urandom_range(0, 1));
    wait_done("done_timeout");
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic start_only(input logic m);
    @(negedge clk);
    bif.mode = m; bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
  endtask

  initial begin
    int   runs;
    logic m;
    bif.start = 1'b0; bif.abort = 1'b0; bif.mode = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_state", 64'(out_vec()), 64'(RESET_VEC));
    @(negedge clk) reset_n = 1'b1;

    run_full(1'b0, 0, 1'b0);
    run_full(1'b1, 0, 1'b0);
    run_full(1'b0, 1, 1'b0);
    run_full(1'b0, 2, 1'b0);
    run_full(1'b1, 0, 1'b1);

    // abort on the 10th RUN cycle
    fault = 0;
    start_only(1'($urandom_range(0, 1)));
    runs = 0;
    for (int i = 0; i < 100 && runs < 10; i++) begin
      if (bif.busy && !bif.cut_reset) runs++;
      if (runs < 10) @(negedge clk);
    end
    check("abort_reached_run10", 64'(runs), 64'd10);
    bif.abort = 1'b1;
    @(negedge clk);
    bif.abort = 1'b0;
    check("abort_idle", 64'({bif.busy, bif.done, bif.pass, bif.cut_reset, bif.cut_x}),
          64'({3'b000, 1'b1, 6'h00}));
    repeat (3) @(negedge clk);
    check("abort_stays_idle", 64'({bif.busy, bif.done}), 64'd0);
    run_full(1'b0, 0, 1'b0);

    // asynchronous reset in the middle of RUN
    start_only(1'b1);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check("async_reset_mid_run", 64'(out_vec()), 64'(RESET_VEC));
    @(negedge clk) reset_n = 1'b1;

    // start held high for the whole run must not extend it
    m = 1'($urandom_range(0, 1));
    fault = 0;
    push_expected(m, 0);
    @(negedge clk);
    bif.mode = m; bif.start = 1'b1;
    wait_done("held_start_timeout");
    bif.start = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 4; k++)
      run_full(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));

    repeat (3) @(negedge clk);
    check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
